// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: drives an external 1-cycle-latency block RAM as a FIFO, with a 2-entry show-ahead output queue
module bram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_pend_q;
  logic [1:0]        q_cnt_q, q_cnt_d, q_pos;
  logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;
  logic [2:0]        occ;
  logic              push, pop;
  always_comb begin
    in_ready   = !rst && !ram_cnt_q[ADDR_W];
    push       = in_valid && in_ready;
    out_valid  = q_cnt_q != 2'd0;
    pop        = out_valid && out_ready;
    out_data   = q0_q;
    ram_w_en   = push;
    ram_w_addr = wr_ptr_q;
    ram_w_data = in_data;
    // queue slots still claimed after this cycle's pop; issue only if one stays free for the read
    occ        = {1'b0, q_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    ram_r_en   = (ram_cnt_q != '0) && (occ <= 3'd1);
    ram_r_addr = rd_ptr_q;
    count      = {1'b0, ram_cnt_q} + (ADDR_W+2)'(rd_pend_q) + (ADDR_W+2)'(q_cnt_q);
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(ram_r_en);
    ram_cnt_d  = ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(ram_r_en);
    q_pos      = q_cnt_q - {1'b0, pop};
    q_cnt_d    = q_pos + {1'b0, rd_pend_q};
    q0_d       = (rd_pend_q && q_pos == 2'd0) ? ram_r_data : pop ? q1_q : q0_q;
    q1_d       = (rd_pend_q && q_pos == 2'd1) ? ram_r_data : q1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      q_cnt_q   <= '0;
      q0_q      <= '0;
      q1_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= ram_r_en;
      q_cnt_q   <= q_cnt_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: random and directed stimulus against a queue scoreboard with an attached RAM model
module tb_bram_fifo_ctrl;
  logic       clk = 0, rst = 1;
  logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [7:0] in_data = 0, out_data, ram_w_data, ram_r_data;
  logic [5:0] count;
  logic       ram_w_en, ram_r_en;
  logic [3:0] ram_w_addr, ram_r_addr;
  logic [7:0] mem [16];
  logic [7:0] sb [$];
  logic [7:0] prev_d;
  logic       stall_prev;
  int checks = 0, errors = 0, wr_n = 0, rd_n = 0, npush = 0, npop = 0;

  bram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // write and read addresses must step through 0,1,2.. from reset, wrapping at 16
  always @(negedge clk) begin
    if (rst) begin
      wr_n = 0;
      rd_n = 0;
    end else begin
      if (ram_w_en) begin
        chk("w_addr", ram_w_addr, wr_n % 16);
        wr_n++;
      end
      if (ram_r_en) begin
        chk("r_addr", ram_r_addr, rd_n % 16);
        rd_n++;
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    sb.delete();
    stall_prev = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    chk("count", count, sb.size());
    if (sb.size() == 0) chk("ov_empty", out_valid, 0);
    if (sb.size() < 16) chk("in_ready", in_ready, 1);
    if (sb.size() == 18) chk("in_ready_full", in_ready, 0);
    chk("w_en", ram_w_en, in_valid && in_ready);
    if (stall_prev) begin
      chk("stall_v", out_valid, 1);
      chk("stall_d", out_data, prev_d);
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      chk("pop", out_data, sb.pop_front());
      npop++;
    end
    if (in_valid && in_ready) begin
      chk("w_data", ram_w_data, in_data);
      sb.push_back(in_data);
      npush++;
    end
    stall_prev = out_valid && !out_ready;
    prev_d = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a word offered
    rst = 1;
    in_valid = 1;
    in_data = 8'h77;
    #12;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    chk("rst_wen", ram_w_en, 0);
    chk("rst_ren", ram_r_en, 0);
    chk("rst_cnt", count, 0);
    do_reset();
    #1 chk("rel_ir", in_ready, 1);

    // single-word latency
    cycle(1, 8'hA5, 0);
    in_valid = 0;
    @(negedge clk);
    chk("lat_t1_ren", ram_r_en, 1);
    chk("lat_t1_ov", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_t2_ov", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_t3_ov", out_valid, 1);
    chk("lat_t3_d", out_data, 8'hA5);
    chk("lat_t3_cnt", count, 1);
    @(posedge clk);
    #1;

    // fill to capacity, then drain in order
    do_reset();
    for (int i = 0; i < 19; i++) cycle(1, 8'(i), 0);
    chk("full_cnt", count, 18);
    chk("full_ir", in_ready, 0);
    for (int i = 0; i < 20; i++) cycle(0, 8'h0, 1);
    chk("drain_cnt", count, 0);

    // full-rate streaming across pointer wrap
    do_reset();
    npop = 0;
    for (int i = 0; i < 40; i++) cycle(1, 8'(i), 1);
    chk("stream_pops", npop, 37);
    for (int i = 0; i < 5; i++) cycle(0, 8'h0, 1);
    chk("stream_empty", sb.size(), 0);

    // random traffic
    do_reset();
    npush = 0;
    for (int n = 0; n < 4000 && npush < 500; n++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    chk("rand_pushes", npush, 500);
    for (int n = 0; n < 60 && sb.size() > 0; n++) cycle(0, 8'h0, 1);
    chk("rand_drained", sb.size(), 0);

    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 0);
    chk("pre_rst_cnt", count, 5);
    #2 rst = 1;
    #1;
    chk("async_cnt", count, 0);
    chk("async_ov", out_valid, 0);
    sb.delete();
    stall_prev = 0;
    in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = 8'h3C;
    #1 chk("post_rst_waddr", ram_w_addr, 0);
    @(posedge clk);
    #1;
    sb.push_back(8'h3C);
    for (int i = 0; i < 3; i++) cycle(0, 8'h0, 0);
    chk("post_rst_ov", out_valid, 1);
    chk("post_rst_d", out_data, 8'h3C);
    cycle(0, 8'h0, 1);
    chk("post_rst_empty", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
